// File: rtl/muldiv_pkg.sv
// Shared types and encodings for the muldiv_seq multiply/divide sequencer.
package muldiv_pkg;

   typedef enum logic [2:0] {
      IDLE,
      MUL_STEP,
      DIV_CMP,
      DIV_SUB,
      DONE
   } muldiv_state_t;

   localparam logic [1:0] MD_MUL  = 2'b00;
   localparam logic [1:0] MD_DIVU = 2'b01;
   localparam logic [1:0] MD_REMU = 2'b10;

   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0001;
   localparam logic [3:0] ALU_BLT = 4'b0111;

endpackage

// File: rtl/muldiv_seq.sv
// Iterative MUL/DIVU/REMU sequencer that borrows the EX-stage ALU for every add, subtract and compare.
// Optional macro MULDIV_EARLY_EXIT_EN stops a multiply once no multiplier bits remain.
module muldiv_seq
   import muldiv_pkg::*;
#(
   parameter int DATA_WIDTH    = 32,
   parameter int OPCODE_LENGTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic [1:0]               op,
   input  logic [DATA_WIDTH-1:0]    operand_a,
   input  logic [DATA_WIDTH-1:0]    operand_b,
   input  logic                     flush,
   output logic                     busy,
   output logic                     done,
   output logic [DATA_WIDTH-1:0]    result,
   output logic                     alu_req,
   output logic [DATA_WIDTH-1:0]    alu_srcA,
   output logic [DATA_WIDTH-1:0]    alu_srcB,
   output logic [OPCODE_LENGTH-1:0] alu_operation,
   input  logic [DATA_WIDTH-1:0]    alu_result
);

   localparam int CW = $clog2(DATA_WIDTH) + 1;
   localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

   muldiv_state_t state, stateNext, acceptState;
   logic [1:0]            opReg;
   logic [DATA_WIDTH-1:0] acc, mcand, mplier;
   logic [DATA_WIDTH-1:0] rem, quo, divisor;
   logic                  carry, ge, subPhase;
   logic [CW-1:0]         count;
   logic                  accept, lastStep;
   logic [DATA_WIDTH-1:0] immResult, finalResult;

   // Where an accepted request goes, and the answer for requests that need no iteration.
   always_comb begin
      acceptState = DONE;
      immResult   = '0;
      case (op)
         MD_MUL: begin
`ifdef MULDIV_EARLY_EXIT_EN
            if (operand_b != '0) acceptState = MUL_STEP;
`else
            acceptState = MUL_STEP;
`endif
         end
         MD_DIVU: begin
            if (operand_b != '0) acceptState = DIV_CMP;
            else                 immResult   = '1;
         end
         MD_REMU: begin
            if (operand_b != '0) acceptState = DIV_CMP;
            else                 immResult   = operand_a;
         end
         default: ;
      endcase
   end

   // Next state plus ALU steering; the ALU sees zeros whenever the sequencer does not own it.
   always_comb begin
      stateNext     = state;
      accept        = 1'b0;
      lastStep      = 1'b0;
      finalResult   = '0;
      busy          = 1'b0;
      done          = 1'b0;
      alu_srcA      = '0;
      alu_srcB      = '0;
      alu_operation = '0;
      case (state)
         IDLE: accept = start;
         MUL_STEP: begin
            busy          = 1'b1;
            alu_srcA      = acc;
            alu_srcB      = mcand;
            alu_operation = OPCODE_LENGTH'(ALU_ADD);
`ifdef MULDIV_EARLY_EXIT_EN
            lastStep      = (count == LAST) || (mplier[DATA_WIDTH-1:1] == '0);
`else
            lastStep      = (count == LAST);
`endif
            finalResult   = mplier[0] ? alu_result : acc;
            if (lastStep) stateNext = DONE;
         end
         DIV_CMP: begin
            busy      = 1'b1;
            stateNext = DIV_SUB;
         end
         DIV_SUB: begin
            busy          = 1'b1;
            alu_srcA      = rem;
            alu_srcB      = divisor;
            alu_operation = subPhase ? OPCODE_LENGTH'(ALU_SUB) : OPCODE_LENGTH'(ALU_BLT);
            lastStep      = subPhase && (count == LAST);
            finalResult   = (opReg == MD_REMU) ? (ge ? alu_result : rem)
                                               : {quo[DATA_WIDTH-1:1], ge};
            if (subPhase) stateNext = lastStep ? DONE : DIV_CMP;
         end
         DONE: begin
            done      = 1'b1;
            stateNext = IDLE;
            accept    = start && !flush;
         end
         default: stateNext = IDLE;
      endcase
      if (accept)        stateNext = acceptState;
      if (busy && flush) stateNext = IDLE;
   end

   assign alu_req = busy;

   // State register and datapath; carry keeps the bit shifted out of R so huge divisors still compare correctly.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         opReg    <= '0;
         acc      <= '0;
         mcand    <= '0;
         mplier   <= '0;
         rem      <= '0;
         quo      <= '0;
         divisor  <= '0;
         carry    <= 1'b0;
         ge       <= 1'b0;
         subPhase <= 1'b0;
         count    <= '0;
         result   <= '0;
      end else begin
         state <= stateNext;
         if (accept) begin
            opReg    <= op;
            acc      <= '0;
            mcand    <= operand_a;
            mplier   <= operand_b;
            rem      <= '0;
            quo      <= operand_a;
            divisor  <= operand_b;
            carry    <= 1'b0;
            ge       <= 1'b0;
            subPhase <= 1'b0;
            count    <= '0;
            if (acceptState == DONE) result <= immResult;
         end else begin
            case (state)
               MUL_STEP: begin
                  if (mplier[0]) acc <= alu_result;
                  mcand  <= mcand << 1;
                  mplier <= mplier >> 1;
                  count  <= count + 1'b1;
               end
               DIV_CMP: begin
                  carry <= rem[DATA_WIDTH-1];
                  rem   <= {rem[DATA_WIDTH-2:0], quo[DATA_WIDTH-1]};
                  quo   <= quo << 1;
               end
               DIV_SUB: begin
                  if (!subPhase) begin
                     ge       <= carry | ~alu_result[0];
                     subPhase <= 1'b1;
                  end else begin
                     subPhase <= 1'b0;
                     count    <= count + 1'b1;
                     if (ge) begin
                        rem    <= alu_result;
                        quo[0] <= 1'b1;
                     end
                  end
               end
               default: ;
            endcase
            if (lastStep && stateNext == DONE) result <= finalResult;
         end
      end
   end

endmodule
